// File: rtl/reg_bank_writer.sv
// Sixteen-entry register bank with a single write port and a 16-cycle
// sequential clear. Every register drives its own output directly.
module reg_bank_writer #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_start,
  output logic             busy,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [WIDTH-1:0] out9,
  output logic [WIDTH-1:0] out10,
  output logic [WIDTH-1:0] out11,
  output logic [WIDTH-1:0] out12,
  output logic [WIDTH-1:0] out13,
  output logic [WIDTH-1:0] out14,
  output logic [WIDTH-1:0] out15
);

  localparam int unsigned NREGS = 16;
  localparam int unsigned AW    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic             w_wr_blocked;

  // Register 0 is hard-wired to zero when ZERO_REG is set; the write is still handshaked.
  assign w_wr_blocked = ZERO_REG && (wr_addr == AW'(0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= AW'(0);
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= WIDTH'(0);
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (wr_valid && !w_wr_blocked) begin
            r_regs[wr_addr] <= wr_data;
          end
          if (clr_start) begin
            r_state <= CLEAR;
            r_cnt   <= AW'(0);
          end
        end
        CLEAR: begin
          // clr_start is deliberately ignored here: no restart, no extension.
          r_regs[r_cnt] <= WIDTH'(0);
          r_cnt         <= r_cnt + AW'(1);
          if (r_cnt == AW'(NREGS - 1)) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign wr_ready = (r_state == IDLE) && !rst;
  assign busy     = (r_state == CLEAR);

  assign out0  = r_regs[0];
  assign out1  = r_regs[1];
  assign out2  = r_regs[2];
  assign out3  = r_regs[3];
  assign out4  = r_regs[4];
  assign out5  = r_regs[5];
  assign out6  = r_regs[6];
  assign out7  = r_regs[7];
  assign out8  = r_regs[8];
  assign out9  = r_regs[9];
  assign out10 = r_regs[10];
  assign out11 = r_regs[11];
  assign out12 = r_regs[12];
  assign out13 = r_regs[13];
  assign out14 = r_regs[14];
  assign out15 = r_regs[15];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Bench for reg_bank_writer: two instances (ZERO_REG=0 and ZERO_REG=1) on shared
// inputs, checked against an array/countdown model of the register bank.
module tb_reg_bank_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_start;
  logic        ready_a, ready_z, busy_a, busy_z;
  logic [31:0] oa [16];
  logic [31:0] oz [16];

  // Reference model: register contents plus remaining clear cycles.
  logic [31:0] m  [16];
  logic [31:0] mz [16];
  int          clr_left;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_a;
    logic [31:0] exp_z;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  reg_bank_writer #(.WIDTH(32), .ZERO_REG(1'b0)) dut_a (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(ready_a),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_start(clr_start), .busy(busy_a),
    .out0(oa[0]), .out1(oa[1]), .out2(oa[2]), .out3(oa[3]),
    .out4(oa[4]), .out5(oa[5]), .out6(oa[6]), .out7(oa[7]),
    .out8(oa[8]), .out9(oa[9]), .out10(oa[10]), .out11(oa[11]),
    .out12(oa[12]), .out13(oa[13]), .out14(oa[14]), .out15(oa[15])
  );

  reg_bank_writer #(.WIDTH(32), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(ready_z),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_start(clr_start), .busy(busy_z),
    .out0(oz[0]), .out1(oz[1]), .out2(oz[2]), .out3(oz[3]),
    .out4(oz[4]), .out5(oz[5]), .out6(oz[6]), .out7(oz[7]),
    .out8(oz[8]), .out9(oz[9]), .out10(oz[10]), .out11(oz[11]),
    .out12(oz[12]), .out13(oz[13]), .out14(oz[14]), .out15(oz[15])
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m[i]  = 32'h0;
      mz[i] = 32'h0;
    end
    clr_left = 0;
  endtask

  // One rising edge of the model using the currently driven inputs.
  task automatic model_edge();
    if (clr_left > 0) begin
      m[16 - clr_left]  = 32'h0;
      mz[16 - clr_left] = 32'h0;
      clr_left--;
    end else begin
      if (wr_valid) begin
        m[wr_addr] = wr_data;
        if (wr_addr != 4'd0) mz[wr_addr] = wr_data;
      end
      if (clr_start) clr_left = 16;
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_busy, exp_ready;
    exp_busy  = (clr_left != 0);
    exp_ready = (clr_left == 0) && !rst;
    for (int i = 0; i < 16; i++) begin
      chk({tag, " out"}, i, oa[i], m[i]);
      chk({tag, " zout"}, i, oz[i], mz[i]);
    end
    chk({tag, " busy"}, 0, 32'(busy_a), 32'(exp_busy));
    chk({tag, " busy"}, 1, 32'(busy_z), 32'(exp_busy));
    chk({tag, " wr_ready"}, 0, 32'(ready_a), 32'(exp_ready));
    chk({tag, " wr_ready"}, 1, 32'(ready_z), 32'(exp_ready));
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] a,
                      input logic [31:0] d, input logic c);
    wr_valid  = v;
    wr_addr   = a;
    wr_data   = d;
    clr_start = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_step(input string tag);
    step(tag, 1'b0, 4'd0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("post_reset");
  endtask

  initial begin
    int busy_cnt;
    int guard;
    wr_valid  = 1'b0;
    wr_addr   = 4'd0;
    wr_data   = 32'h0;
    clr_start = 1'b0;
    do_reset();

    // Sequential writes i*3+1 through a vector table.
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr  = 4'(i);
      tbl[i].data  = 32'(i * 3 + 1);
      tbl[i].exp_a = 32'(i * 3 + 1);
      tbl[i].exp_z = (i == 0) ? 32'h0 : 32'(i * 3 + 1);
    end
    for (int i = 0; i < 16; i++) begin
      step("seqwr", 1'b1, tbl[i].addr, tbl[i].data, 1'b0);
      chk("seqwr_tbl", i, oa[tbl[i].addr], tbl[i].exp_a);
      chk("seqwr_tbl_z", i, oz[tbl[i].addr], tbl[i].exp_z);
    end
    for (int i = 0; i < 4; i++) idle_step("persist");

    // Full clear after loading all ones; count busy cycles.
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 4'(i), 32'hFFFF_FFFF, 1'b0);
    step("clr_pulse", 1'b0, 4'd0, 32'h0, 1'b1);
    busy_cnt = 1;
    for (int k = 0; k < 17; k++) begin
      idle_step("clear");
      if (busy_a) busy_cnt++;
    end
    chk("clear_busy_cycles", 0, 32'(busy_cnt), 32'd16);

    // Write held through a clear lands on the first IDLE edge.
    step("clr_hold", 1'b0, 4'd0, 32'h0, 1'b1);
    guard = 0;
    while (clr_left != 0 && guard < 40) begin
      step("hold_wr", 1'b1, 4'd5, 32'hA5A5_A5A5, 1'b0);
      chk("hold_wr_blocked", 5, oa[5], 32'h0);
      guard++;
    end
    chk("hold_wr_bound", 0, 32'(clr_left), 32'd0);
    step("hold_wr_accept", 1'b1, 4'd5, 32'hA5A5_A5A5, 1'b0);
    chk("hold_wr_final", 5, oa[5], 32'hA5A5_A5A5);
    idle_step("hold_done");

    // Simultaneous write + clear; a re-pulse mid-clear must not extend it.
    step("wr_and_clr", 1'b1, 4'd15, 32'h1234_5678, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step("wrclr", 1'b0, 4'd0, 32'h0, (k == 8));
      chk("wrclr_out15", k, oa[15], (k < 16) ? 32'h1234_5678 : 32'h0);
    end
    chk("wrclr_busy_end", 0, 32'(busy_a), 32'd0);

    // Asynchronous reset in cycle 8 of a clear.
    for (int i = 8; i < 16; i++) step("fill_dead", 1'b1, 4'(i), 32'hDEAD_BEEF, 1'b0);
    step("clr_abort", 1'b0, 4'd0, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++) idle_step("pre_abort");
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    #2;
    rst = 1'b0;
    #1;
    check_all("rst_release");
    step("after_rst_wr", 1'b1, 4'd3, 32'h7, 1'b0);
    chk("after_rst_out3", 3, oa[3], 32'h7);

    // ZERO_REG instance: address 0 stays zero, mux sweep matches.
    step("z_wr0", 1'b1, 4'd0, 32'h55, 1'b0);
    step("z_wr1", 1'b1, 4'd1, 32'h66, 1'b0);
    chk("z_out0", 0, oz[0], 32'h0);
    chk("z_out1", 1, oz[1], 32'h66);
    chk("a_out0", 0, oa[0], 32'h55);
    for (int sel = 0; sel < 16; sel++) begin
      logic [31:0] mux_out;
      mux_out = oz[4'(sel)];
      chk("z_mux", sel, mux_out, mz[sel]);
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_writer.md
REG_BANK_WRITER -- requirements
Module: reg_bank_writer

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register and of wr_data.
REQ-002 Parameter ZERO_REG, default 0: when 1, register 0 is read-only zero.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 wr_valid  input  1: write request present.
REQ-006 wr_ready  output  1: block accepts a write this cycle.
REQ-007 wr_addr  input  4: target register index 0..15.
REQ-008 wr_data  input  WIDTH: value to store.
REQ-009 clr_start  input  1: single-cycle pulse requesting a clear of all 16 registers.
REQ-010 busy  output  1: clear sequence in progress.
REQ-011 out0 .. out15  output  WIDTH each: current register contents; these drive in0..in15 of the 16-to-1 read mux.

Function
REQ-012 The block SHALL hold 16 registers of WIDTH bits, and each outN SHALL be driven directly from register N with no combinational path from the inputs.
REQ-013 The block SHALL implement a two-state FSM with states IDLE and CLEAR.
REQ-014 wr_ready SHALL equal (state == IDLE) AND NOT rst.
REQ-015 A write SHALL be accepted on a rising edge where wr_valid and wr_ready are both 1.
- Register wr_addr takes wr_data.
- The new value appears on out[wr_addr] after that edge, giving 1-cycle latency.
REQ-016 Only the addressed register SHALL change on an accepted write; all other registers SHALL hold.
REQ-017 A write with wr_valid=1 while wr_ready=0 SHALL be ignored, not queued; the requester holds wr_valid until it sees ready.
REQ-018 When ZERO_REG=1, writes to address 0 SHALL be accepted with ready asserted but SHALL leave out0 at 0.
REQ-019 IDLE->CLEAR SHALL occur on an edge where state is IDLE and clr_start=1; a 4-bit clear counter loads 0 on that edge.
REQ-020 In CLEAR, each edge SHALL zero register[counter] and increment the counter.
REQ-021 CLEAR->IDLE SHALL occur on the edge that zeroes register 15.
- CLEAR lasts exactly 16 cycles.
- The counter wraps 15->0.
REQ-022 busy SHALL be 1 exactly while state is CLEAR.
REQ-023 clr_start asserted while in CLEAR SHALL be ignored, with no restart and no extension of the sequence.
REQ-024 When wr_valid, wr_ready and clr_start are all 1 in the same IDLE cycle:
- The write SHALL complete on that edge.
- CLEAR SHALL begin on that same edge.
- The written register is zeroed later in the sequence.
REQ-025 Register contents SHALL persist indefinitely in IDLE with no requests.

Reset
REQ-026 While rst=1, all 16 registers SHALL be 0, state SHALL be IDLE, the counter SHALL be 0, busy SHALL be 0 and wr_ready SHALL be 0.
REQ-027 Assertion of rst SHALL take effect immediately, independent of clk.
REQ-028 rst asserted mid-CLEAR SHALL abort the sequence and zero all registers.
REQ-029 After rst deasserts, the block SHALL be in IDLE with wr_ready=1 from that cycle on.

Verification
REQ-030 Reset, then write addr i with data i*3+1 for i=0..15 on consecutive cycles -> each outi equals i*3+1 one cycle after its write; all other outputs unchanged at each step.
REQ-031 Load all 16 registers with 0xFFFFFFFF, pulse clr_start -> busy=1 for exactly 16 cycles; outk reads 0 from cycle k+1 after the pulse; wr_ready=0 throughout; busy=0 and wr_ready=1 after.
REQ-032 During CLEAR, hold wr_valid=1 with addr 5, data 0xA5A5A5A5 -> no write during CLEAR; the write is accepted on the first IDLE edge and out5=0xA5A5A5A5 at the end.
REQ-033 Same cycle: write addr 15 with 0x12345678 and pulse clr_start -> out15=0x12345678 for 15 cycles, then 0 at cycle 16 of the clear.
REQ-034 Assert rst asynchronously in cycle 8 of a clear with registers 8..15 at 0xDEADBEEF -> all outputs 0 and busy=0 immediately; after release a write to addr 3 with 0x7 is accepted and out3=7.
REQ-035 With ZERO_REG=1, write addr 0 with 0x55 and addr 1 with 0x66 -> out0=0 and out1=0x66; feeding out0..out15 to the read mux and sweeping sel 0..15 returns the matching register values.
